dcache_miss: RTL

Data-cache miss handler between the memory1 stage and the dcache CAM. On a CAM miss, memory1 hands over the physical address; the block scans the target line's CAM entries, writes back dirty words over the memory bus, refills the line word-by-word, and merges store data into the requested word. It then returns the requested word to memory1. It drives the dcache `mem1_cam_*` read/write ports.

---
 rtl/dcache_miss.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_miss.sv
// dcache_miss: data-cache miss handler sitting between memory1 and the dcache CAM.
//
// On a miss the handler scans every CAM entry of the target line (word 0
// upward), writes back entries that are valid+dirty over the memory bus,
// refills the whole line from the bus, and merges store data into the
// requested word. The requested (merged) word is returned on miss_rdata
// together with a one-cycle miss_done pulse.
//
// Optional feature macro: DCACHE_MISS_CRITICAL_FIRST_EN
//   defined   : the refill starts at the requested word and wraps around
//   undefined : the refill always runs from word 0 upward
//
// Ports
//   clk_core, reset_n            core clock, synchronous active-low reset
//   miss_req/write/addr/wdata/wmask   request from memory1 (held until done)
//   miss_busy, miss_done, miss_rdata  status and result to memory1
//   cam_read_*                   CAM read port (result one cycle later on dc_cam_read_*)
//   cam_write_*                  CAM write port (data + tag/flags)
//   bus_req/we/addr/wdata        memory bus request, held until bus_ack
//   bus_ack, bus_rdata           one-cycle acknowledge with read data
//   dbg_state                    current FSM state, for checkers
//
// Handshake: a bus request is asserted and held with stable address/data
// until the cycle in which bus_ack is sampled high; that cycle completes the
// transfer. bus_ack while bus_req is low has no effect.
//
// CAM flags: bit0 = valid, bit1 = dirty.

module dcache_miss #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        miss_req,
  input  logic        miss_write,
  input  logic [28:2] miss_addr,
  input  logic [31:0] miss_wdata,
  input  logic [3:0]  miss_wmask,
  output logic        miss_busy,
  output logic        miss_done,
  output logic [31:0] miss_rdata,
  output logic        cam_read_req,
  output logic [11:2] cam_read_index,
  output logic [28:12] cam_read_tag_in,
  input  logic [28:12] dc_cam_read_tag_out,
  input  logic [31:0] dc_cam_read_data,
  input  logic [1:0]  dc_cam_read_flags,
  output logic [11:2] cam_write_index,
  output logic        cam_write_req_data,
  output logic [31:0] cam_write_data,
  output logic [3:0]  cam_write_mask,
  output logic        cam_write_req_tag_flags,
  output logic [28:12] cam_write_tag,
  output logic [1:0]  cam_write_flags,
  output logic        bus_req,
  output logic        bus_we,
  output logic [28:2] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [2:0]  dbg_state
);

  localparam int LG = $clog2(LINE_WORDS);
  // Counter is at least one bit wide; for a one-word line it is masked to 0.
  localparam int CW = (LG == 0) ? 1 : LG;
  localparam logic [CW-1:0] LAST   = CW'(LINE_WORDS - 1);
  localparam logic [9:0]    WMASK10 = 10'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WB_READ  = 3'd1,
    S_WB_CHECK = 3'd2,
    S_WB_BUS   = 3'd3,
    S_FILL_BUS = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] i_q, i_d;
  logic [28:2]   addr_q;
  logic          write_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic [28:12]  vtag_q;
  logic [31:0]   vdata_q;
  logic [31:0]   rdata_q;

  logic          accept, vic_load, rdata_load, adv;
  logic [9:0]    line_idx, scan_idx, fill_idx;
  logic [CW-1:0] req_word, fill_start, fill_word;
  logic          is_last;
  logic [31:0]   merged, fill_data;

  // Word counter i is the scan word during write-back and the number of
  // words already filled during refill; the fill word is derived from it so
  // one counter serves both phases.
  always_comb begin
    line_idx = addr_q[11:2] & ~WMASK10;
    req_word = addr_q[CW+1:2] & LAST;
`ifdef DCACHE_MISS_CRITICAL_FIRST_EN
    fill_start = req_word;
`else
    fill_start = '0;
`endif
    fill_word = (fill_start + i_q) & LAST;
    scan_idx  = line_idx | (10'(i_q) & WMASK10);
    fill_idx  = line_idx | (10'(fill_word) & WMASK10);
    is_last   = (i_q == LAST);
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wmask_q[b] ? wdata_q[8*b +: 8] : bus_rdata[8*b +: 8];
    end
    fill_data = write_q ? merged : bus_rdata;
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      if (accept) begin
        addr_q  <= miss_addr;
        write_q <= miss_write;
        wdata_q <= miss_wdata;
        wmask_q <= miss_wmask;
      end
      if (vic_load) begin
        vtag_q  <= dc_cam_read_tag_out;
        vdata_q <= dc_cam_read_data;
      end
      if (rdata_load) begin
        rdata_q <= fill_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    accept     = 1'b0;
    vic_load   = 1'b0;
    rdata_load = 1'b0;
    adv        = 1'b0;

    cam_read_req            = 1'b0;
    cam_read_index          = '0;
    cam_read_tag_in         = '0;
    cam_write_index         = '0;
    cam_write_req_data      = 1'b0;
    cam_write_data          = '0;
    cam_write_mask          = '0;
    cam_write_req_tag_flags = 1'b0;
    cam_write_tag           = '0;
    cam_write_flags         = '0;
    bus_req                 = 1'b0;
    bus_we                  = 1'b0;
    bus_addr                = '0;
    bus_wdata               = '0;

    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          accept  = 1'b1;
          i_d     = '0;
          state_d = S_WB_READ;
        end
      end
      S_WB_READ: begin
        cam_read_req    = 1'b1;
        cam_read_index  = scan_idx;
        cam_read_tag_in = addr_q[28:12];
        state_d         = S_WB_CHECK;
      end
      S_WB_CHECK: begin
        if (dc_cam_read_flags == 2'b11) begin
          vic_load = 1'b1;
          state_d  = S_WB_BUS;
        end else begin
          adv = 1'b1;
        end
      end
      S_WB_BUS: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {vtag_q, scan_idx};
        bus_wdata = vdata_q;
        adv       = bus_ack;
      end
      S_FILL_BUS: begin
        bus_req  = 1'b1;
        bus_addr = {addr_q[28:12], fill_idx};
        if (bus_ack) begin
          cam_write_index         = fill_idx;
          cam_write_req_data      = 1'b1;
          cam_write_mask          = 4'hF;
          cam_write_req_tag_flags = 1'b1;
          cam_write_tag           = addr_q[28:12];
          if (fill_word == req_word) begin
            rdata_load      = 1'b1;
            cam_write_data  = fill_data;
            cam_write_flags = write_q ? 2'b11 : 2'b01;
          end else begin
            cam_write_data  = bus_rdata;
            cam_write_flags = 2'b01;
          end
          if (is_last) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d = CW'(i_q + 1'b1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared scan advance: after the last scanned word the refill begins.
    if (adv) begin
      if (is_last) begin
        i_d     = '0;
        state_d = S_FILL_BUS;
      end else begin
        i_d     = CW'(i_q + 1'b1);
        state_d = S_WB_READ;
      end
    end
  end

  assign miss_busy  = (state_q != S_IDLE);
  assign miss_done  = (state_q == S_DONE);
  assign miss_rdata = rdata_q;
  assign dbg_state  = state_q;

endmodule
